// File: rtl/dcm_freq_arbiter.sv
// Arbitrates thermal/host/governor multiplier requests and serialises the
// LoadD / LoadM / GO programming frame onto the DCM_CLKGEN PROGEN/PROGDATA port.
module dcm_freq_arbiter #(
  parameter int MAXIMUM_MULTIPLIER = 64,
  parameter int MINIMUM_MULTIPLIER = 2,
  parameter int INITIAL_MULTIPLIER = 16,
  parameter int DIVIDER            = 8,
  parameter int DONE_TIMEOUT       = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       therm_req,
  input  logic [7:0] therm_mult,
  output logic       therm_ack,
  input  logic       host_req,
  input  logic [7:0] host_mult,
  output logic       host_ack,
  input  logic       gov_req,
  input  logic [7:0] gov_mult,
  output logic       gov_ack,
  output logic       dcm_prog_en,
  output logic       dcm_prog_data,
  input  logic       dcm_prog_done,
  output logic [7:0] current_mult,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [7:0]    MAX_M     = 8'(MAXIMUM_MULTIPLIER);
  localparam logic [7:0]    MIN_M     = 8'(MINIMUM_MULTIPLIER);
  localparam logic [7:0]    INIT_M    = 8'(INITIAL_MULTIPLIER);
  localparam logic [7:0]    D_M1      = 8'(DIVIDER - 1);
  localparam int            TW        = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(DONE_TIMEOUT);
  localparam logic [4:0]    LAST_STEP = 5'd25;

  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_SEND, ST_WAIT} state_t;

  state_t        state_r, state_n;
  logic [4:0]    step_r, step_n;
  logic [7:0]    m_r, m_n;
  logic [TW-1:0] cnt_r, cnt_n;
  logic [7:0]    cur_n;
  logic          err_n;
  logic [2:0]    acks_r, acks_n;
  logic [7:0]    sel_mult_s;
  logic [1:0]    bits_n;
  logic          busy_n;

  function automatic logic [7:0] clamp_mult(input logic [7:0] req);
    logic [7:0] v;
    v = (req > MAX_M) ? MAX_M : req;
    return (v < MIN_M) ? MIN_M : v;
  endfunction

  // {en,data} for one step of the programming frame; D-1 and M-1 go out LSB first.
  function automatic logic [1:0] frame_bits(input logic [4:0] step, input logic [7:0] m);
    logic [7:0] mm1;
    logic [2:0] idx;
    logic [1:0] r;
    mm1 = m - 8'd1;
    idx = 3'd0;
    if (step <= 5'd1) begin
      r = (step == 5'd0) ? 2'b11 : 2'b10;
    end else if (step <= 5'd9) begin
      idx = 3'(step - 5'd2);
      r   = {1'b1, D_M1[idx]};
    end else if (step == 5'd11 || step == 5'd12) begin
      r = 2'b11;
    end else if (step >= 5'd13 && step <= 5'd20) begin
      idx = 3'(step - 5'd13);
      r   = {1'b1, mm1[idx]};
    end else if (step == 5'd23) begin
      r = 2'b10;
    end else begin
      r = 2'b00;
    end
    return r;
  endfunction

  // Next-state, arbitration and next values of every registered output.
  always_comb begin
    state_n    = state_r;
    step_n     = step_r;
    m_n        = m_r;
    cnt_n      = cnt_r;
    cur_n      = current_mult;
    err_n      = timeout_err;
    acks_n     = 3'b000;
    sel_mult_s = current_mult;
    case (state_r)
      ST_BOOT: begin
        state_n = ST_SEND;
        step_n  = 5'd0;
        m_n     = clamp_mult(INIT_M);
      end
      ST_IDLE: begin
        // The cycle after an ack is a holdoff so a requester dropping req on the ack is not re-served.
        if (acks_r == 3'b000) begin
          if (therm_req) begin
            acks_n     = 3'b100;
            sel_mult_s = clamp_mult(therm_mult);
          end else if (host_req) begin
            acks_n     = 3'b010;
            sel_mult_s = clamp_mult(host_mult);
          end else if (gov_req) begin
            acks_n     = 3'b001;
            sel_mult_s = clamp_mult(gov_mult);
          end else begin
            acks_n     = 3'b000;
          end
          if (acks_n != 3'b000 && sel_mult_s != current_mult) begin
            state_n = ST_SEND;
            step_n  = 5'd0;
            m_n     = sel_mult_s;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (step_r == LAST_STEP) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end else begin
          step_n = step_r + 5'd1;
        end
      end
      ST_WAIT: begin
        if (dcm_prog_done) begin
          cur_n   = m_r;
          state_n = ST_IDLE;
        end else if (cnt_r == TIMEOUT_V) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_r + TW'(1);
        end
      end
      default: state_n = ST_BOOT;
    endcase
    if (state_n == ST_SEND) begin
      bits_n = frame_bits(step_n, m_n);
    end else begin
      bits_n = 2'b00;
    end
    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BOOT;
      step_r        <= 5'd0;
      m_r           <= 8'd0;
      cnt_r         <= '0;
      acks_r        <= 3'b000;
      current_mult  <= 8'd0;
      timeout_err   <= 1'b0;
      dcm_prog_en   <= 1'b0;
      dcm_prog_data <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_r       <= state_n;
      step_r        <= step_n;
      m_r           <= m_n;
      cnt_r         <= cnt_n;
      acks_r        <= acks_n;
      current_mult  <= cur_n;
      timeout_err   <= err_n;
      dcm_prog_en   <= bits_n[1];
      dcm_prog_data <= bits_n[0];
      busy          <= busy_n;
    end
  end

  assign therm_ack = acks_r[2];
  assign host_ack  = acks_r[1];
  assign gov_ack   = acks_r[0];

endmodule
